// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array sequencer slice: array geometry,
// BRAM widths, compute cycle counts, FSM states, scratch-pad (SP) word map and
// status codes, plus two small helpers used by the controller.
// ---------------------------------------------------------------------------
package sa_pkg;

  localparam int DIM    = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OS_CYC = 3*DIM - 2;
  localparam int WS_CYC = 4*DIM - 2;

  // Width of a row/col index, and of a bound (1..DIM) or a job dimension field.
  localparam int IDX_W = $clog2(DIM);
  localparam int BND_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_ERR,
    S_LOAD,
    S_CLR,
    S_RUN,
    S_STORE,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] SP_START = 32'd0;
  localparam logic [ADDR_W-1:0] SP_MODE  = 32'd4;
  localparam logic [ADDR_W-1:0] SP_M     = 32'd8;
  localparam logic [ADDR_W-1:0] SP_K     = 32'd12;
  localparam logic [ADDR_W-1:0] SP_N     = 32'd16;
  localparam logic [ADDR_W-1:0] SP_STAT  = 32'd20;

  localparam logic [DATA_W-1:0] STAT_DONE = 32'd1;
  localparam logic [DATA_W-1:0] STAT_ERR  = 32'd2;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Byte address of element (r, c) in a row-major matrix with the given row
  // stride; the element index is scaled by 4 so bits [1:0] are always zero.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] c,
                                                  input logic [BND_W-1:0] stride);
    logic [ADDR_W-1:0] lin;
    lin = ADDR_W'(r) * ADDR_W'(stride) + ADDR_W'(c);
    return lin << 2;
  endfunction

  // A job dimension is legal when it lies in 1..DIM.
  function automatic logic dim_ok(input logic [BND_W-1:0] v);
    return (v != '0) && (v <= BND_W'(DIM));
  endfunction

endpackage

// File: rtl/sa_ctrl_if.sv
// ---------------------------------------------------------------------------
// sa_ctrl_if
// Bundles every bus the sequencer talks to:
//   SP port B  : sp_addr, sp_din, sp_we (out), sp_dout (in, 1-cycle latency)
//   A/W BRAMs  : a_addr, w_addr read addresses
//   operand RF : ld_we, ld_row, ld_col, ld_a_zero, ld_w_zero
//   array      : sa_mode, sa_clear, sa_run
//   O BRAM     : o_addr, o_we, o_row, o_col (result-mux select)
// master = sequencer side, slave = memory/array side.
// ---------------------------------------------------------------------------
interface sa_ctrl_if;
  import sa_pkg::*;

  logic [ADDR_W-1:0] sp_addr;
  logic [DATA_W-1:0] sp_dout;
  logic [DATA_W-1:0] sp_din;
  logic [3:0]        sp_we;

  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] w_addr;

  logic              ld_we;
  logic [IDX_W-1:0]  ld_row;
  logic [IDX_W-1:0]  ld_col;
  logic              ld_a_zero;
  logic              ld_w_zero;

  logic              sa_mode;
  logic              sa_clear;
  logic              sa_run;

  logic [ADDR_W-1:0] o_addr;
  logic [3:0]        o_we;
  logic [IDX_W-1:0]  o_row;
  logic [IDX_W-1:0]  o_col;

  modport master (
    output sp_addr, sp_din, sp_we,
    input  sp_dout,
    output a_addr, w_addr,
    output ld_we, ld_row, ld_col, ld_a_zero, ld_w_zero,
    output sa_mode, sa_clear, sa_run,
    output o_addr, o_we, o_row, o_col
  );

  modport slave (
    input  sp_addr, sp_din, sp_we,
    output sp_dout,
    input  a_addr, w_addr,
    input  ld_we, ld_row, ld_col, ld_a_zero, ld_w_zero,
    input  sa_mode, sa_clear, sa_run,
    input  o_addr, o_we, o_row, o_col
  );

endinterface

// File: rtl/sa_idx_gen.sv
// ---------------------------------------------------------------------------
// sa_idx_gen
// Row-major 2-D index counter. col runs 0..cols-1 inside row 0..rows-1.
// Ports:
//   clk, reset (async, active-low)
//   restart  : force the index back to (0,0); has priority over advance
//   advance  : step to the next element
//   rows/cols: bounds, 1..DIM
//   row/col  : current element
//   wrap     : high while advancing from the final element (index returns to 0)
// ---------------------------------------------------------------------------
module sa_idx_gen
  import sa_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             advance,
  input  logic [BND_W-1:0] rows,
  input  logic [BND_W-1:0] cols,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             wrap
);

  logic last_col;
  logic last_row;

  assign last_col = ({1'b0, col} == cols - BND_W'(1));
  assign last_row = ({1'b0, row} == rows - BND_W'(1));
  assign wrap     = advance && last_col && last_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (restart) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/sa_ctrl.sv
// ---------------------------------------------------------------------------
// sa_ctrl
// Job sequencer for the DIMxDIM systolic array. Polls the SP start word,
// reads mode/M/K/N, loads zero-padded A and W operands, clears and runs the
// array, writes the MxN result row-major to O BRAM and posts status in SP.
// Ports:
//   clk, reset (async, active-low)
//   bus  : sa_ctrl_if master (SP, A/W, operand RF, array, O BRAM)
//   busy : high whenever the FSM is not IDLE
//   err  : sticky illegal-config flag, cleared when the next job starts
// ---------------------------------------------------------------------------
module sa_ctrl
  import sa_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  sa_ctrl_if.master bus,
  output logic      busy,
  output logic      err
);

  state_e           state;
  state_e           state_nxt;
  logic [5:0]       cnt;
  logic             poll_ok;

  logic             mode_q;
  logic [BND_W-1:0] m_q;
  logic [BND_W-1:0] k_q;
  logic [BND_W-1:0] n_q;

  logic [BND_W-1:0] n_in;
  logic             start_seen;
  logic             cfg_ok;
  logic [5:0]       run_last;

  logic             ld_tail;
  logic             ld_issue;
  logic             ld_wrap;
  logic [IDX_W-1:0] ld_r;
  logic [IDX_W-1:0] ld_c;

  logic             st_adv;
  logic             st_wrap;
  logic [IDX_W-1:0] st_r;
  logic [IDX_W-1:0] st_c;

  logic             ld_we_q;
  logic [IDX_W-1:0] ld_row_q;
  logic [IDX_W-1:0] ld_col_q;
  logic             ld_a_zero_q;
  logic             ld_w_zero_q;

  logic             sp_dout_unused;

  assign sp_dout_unused = ^bus.sp_dout[DATA_W-1:BND_W];

  // The SP read data lags the address by a cycle, so the word seen in the
  // first IDLE cycle belongs to whatever the previous state addressed (after
  // DONE/ERR that can be a read-first copy of the start word being cleared).
  // Only trust sp_dout once IDLE has itself driven the poll address.
  assign start_seen = poll_ok && bus.sp_dout[0];

  // N arrives on sp_dout in the last CFG cycle, the same edge it is latched.
  assign n_in   = bus.sp_dout[BND_W-1:0];
  assign cfg_ok = dim_ok(m_q) && dim_ok(k_q) && dim_ok(n_in);

  assign run_last = (mode_q == MODE_OS) ? 6'(OS_CYC - 1) : 6'(WS_CYC - 1);

  assign ld_issue = (state == S_LOAD) && !ld_tail;
  assign st_adv   = (state == S_STORE);

  sa_idx_gen u_ld_idx (
    .clk     (clk),
    .reset   (reset),
    .restart (state != S_LOAD),
    .advance (ld_issue),
    .rows    (BND_W'(DIM)),
    .cols    (BND_W'(DIM)),
    .row     (ld_r),
    .col     (ld_c),
    .wrap    (ld_wrap)
  );

  sa_idx_gen u_st_idx (
    .clk     (clk),
    .reset   (reset),
    .restart (state != S_STORE),
    .advance (st_adv),
    .rows    (m_q),
    .cols    (n_q),
    .row     (st_r),
    .col     (st_c),
    .wrap    (st_wrap)
  );

  // State register plus a shared per-state cycle counter that restarts on
  // every state change (used by CFG, ERR, RUN and DONE).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      poll_ok <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state || state == S_IDLE) ? '0 : cnt + 6'd1;
      poll_ok <= (state == S_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_seen)       state_nxt = S_CFG;
      S_CFG:   if (cnt == 6'd4)      state_nxt = cfg_ok ? S_LOAD : S_ERR;
      S_ERR:   if (cnt == 6'd1)      state_nxt = S_IDLE;
      S_LOAD:  if (ld_tail)          state_nxt = S_CLR;
      S_CLR:                         state_nxt = S_RUN;
      S_RUN:   if (cnt == run_last)  state_nxt = S_STORE;
      S_STORE: if (st_wrap)          state_nxt = S_DONE;
      S_DONE:  if (cnt == 6'd1)      state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // Job registers: CFG cycle n captures the word addressed in cycle n-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_WS;
      m_q    <= '0;
      k_q    <= '0;
      n_q    <= '0;
    end else if (state == S_CFG) begin
      unique case (cnt)
        6'd1:    mode_q <= bus.sp_dout[0];
        6'd2:    m_q    <= bus.sp_dout[BND_W-1:0];
        6'd3:    k_q    <= bus.sp_dout[BND_W-1:0];
        6'd4:    n_q    <= n_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start_seen) begin
      err <= 1'b0;
    end else if (state == S_ERR) begin
      err <= 1'b1;
    end
  end

  // LOAD issues DIM*DIM reads, then spends one tail cycle so the last
  // element's register-file write (one cycle behind the address) lands.
  // The write strobe and its index/padding flags are delayed to match the
  // BRAM read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_tail     <= 1'b0;
      ld_we_q     <= 1'b0;
      ld_row_q    <= '0;
      ld_col_q    <= '0;
      ld_a_zero_q <= 1'b0;
      ld_w_zero_q <= 1'b0;
    end else begin
      if (state != S_LOAD) begin
        ld_tail <= 1'b0;
      end else if (ld_wrap) begin
        ld_tail <= 1'b1;
      end
      ld_we_q     <= ld_issue;
      ld_row_q    <= ld_issue ? ld_r : '0;
      ld_col_q    <= ld_issue ? ld_c : '0;
      ld_a_zero_q <= ld_issue && !(({1'b0, ld_r} < m_q) && ({1'b0, ld_c} < k_q));
      ld_w_zero_q <= ld_issue && !(({1'b0, ld_r} < k_q) && ({1'b0, ld_c} < n_q));
    end
  end

  // SP port: IDLE polls the start word, CFG walks the job words, and
  // ERR/DONE write the status word then clear the start word.
  always_comb begin
    bus.sp_addr = SP_START;
    bus.sp_din  = '0;
    bus.sp_we   = 4'h0;
    unique case (state)
      S_CFG: begin
        unique case (cnt)
          6'd0:    bus.sp_addr = SP_MODE;
          6'd1:    bus.sp_addr = SP_M;
          6'd2:    bus.sp_addr = SP_K;
          6'd3:    bus.sp_addr = SP_N;
          default: bus.sp_addr = SP_START;
        endcase
      end
      S_ERR, S_DONE: begin
        bus.sp_we = 4'hF;
        if (cnt == 6'd0) begin
          bus.sp_addr = SP_STAT;
          bus.sp_din  = (state == S_ERR) ? STAT_ERR : STAT_DONE;
        end
      end
      default: ;
    endcase
  end

  // Operand fetch, array control and result write-back.
  always_comb begin
    bus.a_addr    = ld_issue ? elem_addr(ld_r, ld_c, k_q) : '0;
    bus.w_addr    = ld_issue ? elem_addr(ld_r, ld_c, n_q) : '0;
    bus.ld_we     = ld_we_q;
    bus.ld_row    = ld_row_q;
    bus.ld_col    = ld_col_q;
    bus.ld_a_zero = ld_a_zero_q;
    bus.ld_w_zero = ld_w_zero_q;
    bus.sa_mode   = mode_q;
    bus.sa_clear  = (state == S_CLR);
    bus.sa_run    = (state == S_RUN);
    bus.o_addr    = st_adv ? elem_addr(st_r, st_c, n_q) : '0;
    bus.o_we      = st_adv ? 4'hF : 4'h0;
    bus.o_row     = st_adv ? st_r : '0;
    bus.o_col     = st_adv ? st_c : '0;
  end

  assign busy = (state != S_IDLE);

endmodule

// File: doc/sa_ctrl.md
Name: sa_ctrl

Overview:
- Sequencer for the 8x8 systolic-array engine (modes: 0 = WS, 1 = OS).
- Polls the start word in SP BRAM, then latches the job registers mode/M/K/N.
- Loads A and W element-by-element from their BRAMs into the array's operand register files, zero-padding outside MxK / KxN.
- Runs the array, writes the MxN result to O BRAM row-major, then posts done in SP BRAM.

Parameters:
- DIM, 8, array edge; M/K/N legal range 1..DIM.
- ADDR_W, 32, BRAM byte-address width.
- DATA_W, 32, BRAM word width; one element per word in the low bits.
- OS_CYC, 3*DIM-2, compute cycles in OS mode.
- WS_CYC, 4*DIM-2, compute cycles in WS mode (includes DIM weight-preload cycles).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- sp_addr  out  ADDR_W  SP port-B byte address.
- sp_dout  in  DATA_W  SP read data; 1-cycle latency.
- sp_din  out  DATA_W  SP write data.
- sp_we  out  4  SP byte write enables.
- a_addr / w_addr  out  ADDR_W  A / W BRAM read addresses; 1-cycle latency.
- ld_we  out  1  write strobe for the operand register files, aligned with BRAM data.
- ld_row / ld_col  out  3  operand register-file index.
- ld_a_zero / ld_w_zero  out  1  force the written A / W element to 0 (padding).
- sa_mode  out  1  latched mode to the array.
- sa_clear  out  1  1-cycle pulse clearing accumulators and pipeline.
- sa_run  out  1  array advance enable.
- o_addr  out  ADDR_W  O BRAM byte address.
- o_we  out  4  O BRAM write enable.
- o_row / o_col  out  3  result-mux select; O data comes from the array via that mux.
- busy  out  1  high in all states except IDLE.
- err  out  1  sticky; set by an illegal config, cleared at the next start.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; counters 0; latched mode/M/K/N = 0.
- SP map (byte addresses): 0 start, 4 mode, 8 M, 12 K, 16 N, 20 status. Status values: 1 = done, 2 = error.
- IDLE: sp_addr=0 every cycle. When sp_dout[0]==1 → CFG.
- CFG: issue reads of 4, 8, 12, 16 on consecutive cycles; capture each one cycle later (5 cycles total).
  - mode = bit0; M/K/N = low 4 bits.
  - Any of M/K/N equal to 0 or greater than DIM → ERR.
- ERR: cycle 1: sp_addr=20, sp_din=2, sp_we=F. Cycle 2: sp_addr=0, sp_din=0, sp_we=F. Set err; → IDLE.
- LOAD: index idx = 0..DIM*DIM-1 with r = idx/DIM, c = idx%DIM.
  - a_addr = 4*(r*K+c); w_addr = 4*(r*N+c).
  - One cycle later: ld_we=1, ld_row=r, ld_col=c, ld_a_zero=!(r<M && c<K), ld_w_zero=!(r<K && c<N).
  - Addresses for padded elements are don't-care. Duration DIM*DIM+1 cycles.
  - All address arithmetic is unsigned with no overflow at DIM=8; address bits [1:0] are always 0.
- CLR: sa_clear=1 for one cycle.
- RUN: sa_run=1 for OS_CYC (mode 1) or WS_CYC (mode 0) cycles; counter compared with ==, no early exit.
- STORE: nested i=0..M-1 (outer), j=0..N-1.
  - o_row=i, o_col=j, o_addr=4*(i*N+j), o_we=F; one write per cycle, M*N cycles.
  - The array holds its results stable while sa_run=0.
- DONE: cycle 1: sp_addr=20, sp_din=1, sp_we=F. Cycle 2: sp_addr=0, sp_din=0, sp_we=F (clears start, so no retrigger). → IDLE.
- sp_we is 0 everywhere except ERR and DONE; o_we is 0 outside STORE; ld_we is 0 outside LOAD+1.
- Start word rewritten during a job: ignored; DONE clears it.
- Reset mid-job: immediate return to reset state. No partial O/SP writes after reset deasserts; partial O contents from before reset are undefined.
- Total latency from start seen (K=8 example, M=7, N=3, OS) = 5+65+1+22+21+2 = 116 cycles.

Decomposition:
- Package sa_pkg: FSM state enum (IDLE, CFG, ERR, LOAD, CLR, RUN, STORE, DONE); SP offsets (SP_START=0, SP_MODE=4, SP_M=8, SP_K=12, SP_N=16, SP_STAT=20); STAT_DONE=1, STAT_ERR=2; MODE_WS=0, MODE_OS=1.
- One sub-module, sa_idx_gen: a 2-D row/col counter with programmable bounds, restart and wrap flag. Instantiated for LOAD (DIM x DIM) and STORE (M x N).

Test Plan:
- OS job M=7, K=8, N=3 (A=-2, W=2 model array): start=1 → 21 O writes at o_addr 0..80 step 4; status=1, start=0; busy low after 116 cycles.
- WS job M=8, K=8, N=8: → 64 O writes; RUN lasts 30 cycles; sa_mode=0 throughout.
- Padding job M=3, K=4, N=2: ld_a_zero=1 exactly for r≥3 or c≥4; ld_w_zero=1 exactly for r≥4 or c≥2; last O write at o_addr=20.
- Illegal K=9: → no ld_we/o_we; SP[20]=2, SP[0]=0, err=1. Next valid start clears err.
- Assert reset low during RUN: all outputs 0 that same cycle, FSM=IDLE; rerun M=6, K=7, N=3 completes with 18 writes.
- Start rewritten mid-LOAD: no restart, single DONE sequence, SP[0]=0 at end.
